// File: rtl/combo_lock_pkg.sv
// Shared types, default parameter values and code-digit helper for the combination lock.
package combo_lock_pkg;

  typedef enum logic [2:0] {
    ST_ENTRY,
    ST_CHECK,
    ST_OPEN,
    ST_PROGRAM,
    ST_LOCKOUT
  } state_t;

  localparam int unsigned DEF_CODE_LEN       = 4;
  localparam int unsigned DEF_DIGIT_W        = 4;
  localparam int unsigned DEF_MAX_FAILS      = 3;
  localparam int unsigned DEF_OPEN_CYCLES    = 100000000;
  localparam int unsigned DEF_LOCKOUT_CYCLES = 500000000;
  localparam logic [15:0] DEF_CODE           = 16'h1234;

  localparam int unsigned MAX_CODE_BITS = 256;
  localparam int unsigned MAX_DIGIT_W   = 32;

  // Digit 0 lives in the MSBs of the packed code; caller truncates to its digit width.
  function automatic logic [MAX_DIGIT_W-1:0] code_digit(
    input logic [MAX_CODE_BITS-1:0] code,
    input int unsigned              code_len,
    input int unsigned              digit_w,
    input int unsigned              i
  );
    logic [MAX_CODE_BITS-1:0] shifted;
    shifted = code >> ((code_len - 1 - i) * digit_w);
    return shifted[MAX_DIGIT_W-1:0];
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/combo_lock_ctrl_timer.sv
// Loadable down-counter shared by the OPEN and LOCKOUT dwell periods.
module lock_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Asserted on the last cycle of the period, so a load of N gives exactly N cycles.
  assign done = (count_q <= W'(1));

endmodule

// File: rtl/combo_lock_ctrl.sv
// Combination lock sequencer: digit entry, code check, open/program/lockout control.
module combo_lock_ctrl
  import combo_lock_pkg::*;
#(
  parameter int unsigned CODE_LEN       = DEF_CODE_LEN,
  parameter int unsigned DIGIT_W        = DEF_DIGIT_W,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = DEF_CODE,
  parameter int unsigned MAX_FAILS      = DEF_MAX_FAILS,
  parameter int unsigned OPEN_CYCLES    = DEF_OPEN_CYCLES,
  parameter int unsigned LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enter,
  input  logic                           clear,
  input  logic                           prog,
  input  logic [DIGIT_W-1:0]             digit,
  output logic [$clog2(CODE_LEN)-1:0]    idx,
  output logic                           unlocked,
  output logic                           fail,
  output logic                           lockout,
  output logic                           prog_mode,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt
);

  localparam int unsigned IW   = $clog2(CODE_LEN);
  localparam int unsigned FW   = $clog2(MAX_FAILS + 1);
  localparam int unsigned CW   = CODE_LEN * DIGIT_W;
  localparam int unsigned TW   = $clog2(max_u(OPEN_CYCLES, LOCKOUT_CYCLES) + 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(CODE_LEN - 1);
  localparam logic [FW-1:0] FAIL_LIMIT = FW'(MAX_FAILS);

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           mismatch_q, mismatch_d;
  logic [FW-1:0]  fail_cnt_q, fail_cnt_d;
  logic [CW-1:0]  code_q, code_d;
  logic [CW-1:0]  shadow_q, shadow_d;
  logic           unlocked_q, unlocked_d;
  logic           fail_q, fail_d;
  logic           lockout_q, lockout_d;
  logic           prog_mode_q, prog_mode_d;

  logic [DIGIT_W-1:0] expected_digit;
  logic [FW-1:0]      fail_cnt_inc;
  logic               timer_load;
  logic [TW-1:0]      timer_val;
  logic               timer_done;

  assign expected_digit = DIGIT_W'(code_digit(MAX_CODE_BITS'(code_q), CODE_LEN, DIGIT_W, 32'(idx_q)));
  assign fail_cnt_inc   = (fail_cnt_q == FAIL_LIMIT) ? fail_cnt_q : fail_cnt_q + FW'(1);

  lock_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mismatch_d = mismatch_q;
    fail_cnt_d = fail_cnt_q;
    code_d     = code_q;
    shadow_d   = shadow_q;
    fail_d     = 1'b0;
    timer_load = 1'b0;
    timer_val  = TW'(OPEN_CYCLES);

    case (state_q)
      ST_ENTRY: begin
        if (clear) begin
          idx_d      = '0;
          mismatch_d = 1'b0;
        end else if (enter) begin
          // Every digit is taken before judging, so timing leaks nothing about the code.
          mismatch_d = mismatch_q | (digit != expected_digit);
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_CHECK;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      ST_CHECK: begin
        idx_d      = '0;
        mismatch_d = 1'b0;
        if (!mismatch_q) begin
          state_d    = ST_OPEN;
          fail_cnt_d = '0;
          timer_load = 1'b1;
          timer_val  = TW'(OPEN_CYCLES);
        end else begin
          fail_d     = 1'b1;
          fail_cnt_d = fail_cnt_inc;
          if (fail_cnt_inc == FAIL_LIMIT) begin
            state_d    = ST_LOCKOUT;
            timer_load = 1'b1;
            timer_val  = TW'(LOCKOUT_CYCLES);
          end else begin
            state_d = ST_ENTRY;
          end
        end
      end

      ST_OPEN: begin
        if (timer_done) begin
          state_d = ST_ENTRY;
        end else if (prog) begin
          state_d = ST_PROGRAM;
          idx_d   = '0;
        end
      end

      ST_PROGRAM: begin
        if (clear) begin
          state_d = ST_ENTRY;
          idx_d   = '0;
        end else if (enter) begin
          for (int i = 0; i < int'(CODE_LEN); i++) begin
            if (IW'(i) == idx_q) begin
              shadow_d[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W] = digit;
            end
          end
          if (idx_q == LAST_IDX) begin
            // Whole new code replaces the old one in a single edge.
            code_d  = shadow_d;
            idx_d   = '0;
            state_d = ST_ENTRY;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      ST_LOCKOUT: begin
        if (timer_done) begin
          state_d    = ST_ENTRY;
          fail_cnt_d = '0;
        end
      end

      default: begin
        state_d = ST_ENTRY;
      end
    endcase

    unlocked_d  = (state_d == ST_OPEN) || (state_d == ST_PROGRAM);
    lockout_d   = (state_d == ST_LOCKOUT);
    prog_mode_d = (state_d == ST_PROGRAM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ENTRY;
      idx_q       <= '0;
      mismatch_q  <= 1'b0;
      fail_cnt_q  <= '0;
      code_q      <= DEFAULT_CODE;
      shadow_q    <= '0;
      unlocked_q  <= 1'b0;
      fail_q      <= 1'b0;
      lockout_q   <= 1'b0;
      prog_mode_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mismatch_q  <= mismatch_d;
      fail_cnt_q  <= fail_cnt_d;
      code_q      <= code_d;
      shadow_q    <= shadow_d;
      unlocked_q  <= unlocked_d;
      fail_q      <= fail_d;
      lockout_q   <= lockout_d;
      prog_mode_q <= prog_mode_d;
    end
  end

  assign idx       = idx_q;
  assign unlocked  = unlocked_q;
  assign fail      = fail_q;
  assign lockout   = lockout_q;
  assign prog_mode = prog_mode_q;
  assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Scoreboard bench: stimulus pushes expected open/close/fail/lockout events, a monitor pops them.
module tb_combo_lock_ctrl;

  localparam int EV_OPEN  = 0;
  localparam int EV_CLOSE = 1;
  localparam int EV_FAIL  = 2;
  localparam int EV_LOCK  = 3;

  typedef struct {
    int kind;
    int len;
    int fc;
    int idx;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enter = 1'b0;
  logic       clear = 1'b0;
  logic       prog = 1'b0;
  logic [3:0] digit = 4'd0;
  logic [1:0] idx;
  logic       unlocked;
  logic       fail;
  logic       lockout;
  logic       prog_mode;
  logic [1:0] fail_cnt;

  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];

  combo_lock_ctrl #(
    .CODE_LEN       (4),
    .DIGIT_W        (4),
    .DEFAULT_CODE   (16'h1234),
    .MAX_FAILS      (3),
    .OPEN_CYCLES    (8),
    .LOCKOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enter     (enter),
    .clear     (clear),
    .prog      (prog),
    .digit     (digit),
    .idx       (idx),
    .unlocked  (unlocked),
    .fail      (fail),
    .lockout   (lockout),
    .prog_mode (prog_mode),
    .fail_cnt  (fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic push(input int kind, input int len, input int fc, input int ix);
    ev_t e;
    e.kind = kind; e.len = len; e.fc = fc; e.idx = ix;
    exp_q.push_back(e);
  endtask

  task automatic pulse(input logic e, input logic c, input logic p, input logic [3:0] d);
    digit = d; enter = e; clear = c; prog = p;
    @(posedge clk); #1;
    enter = 1'b0; clear = 1'b0; prog = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic code4(input logic [15:0] c);
    for (int i = 0; i < 4; i++) pulse(1'b1, 1'b0, 1'b0, c[(3-i)*4 +: 4]);
  endtask

  // Monitor: observed events compared in order against the expected queue.
  task automatic report(input int kind, input int len, input int fc, input int ix);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got kind=%0d len=%0d fc=%0d idx=%0d expected none (t=%0t)",
               kind, len, fc, ix, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (e.len >= 0 && e.len != len) ||
          (e.fc >= 0 && e.fc != fc) || (e.idx >= 0 && e.idx != ix)) begin
        errors++;
        $display("FAIL sb_event: got kind=%0d len=%0d fc=%0d idx=%0d expected kind=%0d len=%0d fc=%0d idx=%0d (t=%0t)",
                 kind, len, fc, ix, e.kind, e.len, e.fc, e.idx, $time);
      end else begin
        $display("ok   sb_event kind=%0d len=%0d fc=%0d idx=%0d", kind, len, fc, ix);
      end
    end
  endtask

  logic fail_prev = 1'b0, unl_prev = 1'b0, lock_prev = 1'b0;
  int   fail_len = 0, fail_fc = 0, unl_len = 0, lock_len = 0;

  always @(negedge clk) begin
    if (fail) begin
      if (!fail_prev) begin fail_len = 0; fail_fc = int'(fail_cnt); end
      fail_len++;
    end else if (fail_prev) begin
      report(EV_FAIL, fail_len, fail_fc, -1);
    end
    if (unlocked) begin
      if (!unl_prev) begin
        unl_len = 0;
        report(EV_OPEN, 0, int'(fail_cnt), int'(idx));
      end
      unl_len++;
    end else if (unl_prev) begin
      report(EV_CLOSE, unl_len, -1, -1);
    end
    if (lockout) begin
      if (!lock_prev) lock_len = 0;
      lock_len++;
    end else if (lock_prev) begin
      report(EV_LOCK, lock_len, int'(fail_cnt), -1);
    end
    fail_prev = fail; unl_prev = unlocked; lock_prev = lockout;
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_idx", int'(idx), 0);
    chk("rst_unlocked", int'(unlocked), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_lockout", int'(lockout), 0);
    chk("rst_prog_mode", int'(prog_mode), 0);
    chk("rst_fail_cnt", int'(fail_cnt), 0);

    // Correct code opens for 8 cycles.
    push(EV_OPEN, -1, 0, 0);
    push(EV_CLOSE, 8, -1, -1);
    pulse(1'b1, 1'b0, 1'b0, 4'd1);
    pulse(1'b1, 1'b0, 1'b0, 4'd2);
    chk("entry_idx2", int'(idx), 2);
    pulse(1'b1, 1'b0, 1'b0, 4'd3);
    pulse(1'b1, 1'b0, 1'b0, 4'd4);
    idle(14);

    // Wrong second digit: nothing until the fourth digit.
    push(EV_FAIL, 1, 1, -1);
    pulse(1'b1, 1'b0, 1'b0, 4'd1);
    pulse(1'b1, 1'b0, 1'b0, 4'd9);
    pulse(1'b1, 1'b0, 1'b0, 4'd3);
    chk("no_early_fail", int'(fail), 0);
    chk("no_early_idx", int'(idx), 3);
    pulse(1'b1, 1'b0, 1'b0, 4'd4);
    idle(4);

    // Two more failures reach lockout.
    push(EV_FAIL, 1, 2, -1);
    code4(16'h9999);
    idle(3);
    push(EV_FAIL, 1, 3, -1);
    push(EV_LOCK, 16, 0, -1);
    code4(16'h0000);
    idle(2);
    pulse(1'b1, 1'b0, 1'b0, 4'd1);
    pulse(1'b1, 1'b0, 1'b0, 4'd1);
    chk("lock_idx", int'(idx), 0);
    chk("lock_flag", int'(lockout), 1);
    idle(20);
    chk("lock_done_flag", int'(lockout), 0);
    chk("lock_done_fail_cnt", int'(fail_cnt), 0);

    // Clear aborts partial entry.
    pulse(1'b1, 1'b0, 1'b0, 4'd1);
    pulse(1'b1, 1'b0, 1'b0, 4'd2);
    pulse(1'b0, 1'b1, 1'b0, 4'd0);
    chk("clear_idx", int'(idx), 0);
    push(EV_OPEN, -1, 0, 0);
    push(EV_CLOSE, 8, -1, -1);
    code4(16'h1234);
    idle(14);

    // Simultaneous enter and clear: clear wins.
    pulse(1'b1, 1'b0, 1'b0, 4'd1);
    chk("pre_combo_idx", int'(idx), 1);
    pulse(1'b1, 1'b1, 1'b0, 4'd2);
    chk("enter_clear_idx", int'(idx), 0);
    idle(2);

    // Reprogram the code to 5678.
    push(EV_OPEN, -1, 0, 0);
    push(EV_CLOSE, -1, -1, -1);
    code4(16'h1234);
    idle(1);
    pulse(1'b0, 1'b0, 1'b1, 4'd0);
    chk("prog_mode_on", int'(prog_mode), 1);
    chk("prog_unlocked", int'(unlocked), 1);
    code4(16'h5678);
    idle(1);
    chk("prog_mode_off", int'(prog_mode), 0);
    chk("prog_relocked", int'(unlocked), 0);
    push(EV_FAIL, 1, 1, -1);
    code4(16'h1234);
    idle(3);
    push(EV_OPEN, -1, 0, 0);
    push(EV_CLOSE, 8, -1, -1);
    code4(16'h5678);
    idle(12);

    // Reset during PROGRAM discards everything and restores the default code.
    push(EV_OPEN, -1, 0, 0);
    push(EV_CLOSE, -1, -1, -1);
    code4(16'h5678);
    idle(1);
    pulse(1'b0, 1'b0, 1'b1, 4'd0);
    pulse(1'b1, 1'b0, 1'b0, 4'd5);
    pulse(1'b1, 1'b0, 1'b0, 4'd6);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    chk("rst2_unlocked", int'(unlocked), 0);
    chk("rst2_prog_mode", int'(prog_mode), 0);
    chk("rst2_idx", int'(idx), 0);
    chk("rst2_lockout", int'(lockout), 0);
    chk("rst2_fail_cnt", int'(fail_cnt), 0);
    push(EV_OPEN, -1, 0, 0);
    push(EV_CLOSE, 8, -1, -1);
    code4(16'h1234);
    idle(14);

    chk("sb_pending", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
